// File: rtl/serial_xnor_pkg.sv
// Shared types and helpers for the serial XNOR matcher: FSM state encoding
// and the match-count width function.
package serial_xnor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a count in the range 0..width.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: loads a word, then shifts right so the
// LSB is presented first.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] sr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {1'b0, sr[WIDTH-1:1]};
  end

  assign lsb = sr[0];

endmodule

// File: rtl/serial_xnor_matcher.sv
// Serialises two words LSB-first to an external XNOR-mux stage and counts
// how many bit positions it reports as matching.
module serial_xnor_matcher
  import serial_xnor_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word_a,
  input  logic [WIDTH-1:0] word_b,
  output logic             bit_a,
  output logic             bit_sel,
  input  logic             match_bit,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    match_count,
  output logic             equal
);

  state_t          state, state_nxt;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   idx;
  logic            load;
  logic            shift_en;
  logic            last_bit;
  logic            a_lsb;
  logic            b_lsb;

  assign load     = (state == IDLE) && start;
  assign shift_en = (state == SHIFT);
  assign last_bit = (idx == CW'(WIDTH - 1));

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (word_a),
    .lsb   (a_lsb)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (word_b),
    .lsb   (b_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment before the case keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      idx         <= '0;
      done        <= 1'b0;
      match_count <= '0;
      equal       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        acc <= '0;
        idx <= '0;
      end else if (shift_en) begin
        acc <= acc + CW'(match_bit);
        idx <= idx + CW'(1);
      end
      // Result registers change only on the DONE edge and hold otherwise.
      if (state == DONE) begin
        match_count <= acc;
        equal       <= (acc == CW'(WIDTH));
        done        <= 1'b1;
      end
    end
  end

  assign busy    = shift_en;
  assign bit_a   = shift_en & a_lsb;
  assign bit_sel = shift_en & b_lsb;

endmodule

// File: tb/tb_serial_xnor_matcher.sv
// Self-checking bench: matcher plus an external XNOR-mux, checked every cycle
// against a timing/popcount model and a few hand-computed scenarios.
module tb_serial_xnor_matcher;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] word_a, word_b;
  logic             bit_a, bit_sel, match_bit;
  logic             busy, done, equal;
  logic [CW-1:0]    match_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // External XNOR-mux stage: sel picks a (sel=1) or its inverse (sel=0).
  assign match_bit = bit_sel ? bit_a : ~bit_a;

  serial_xnor_matcher #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word_a      (word_a),
    .word_b      (word_b),
    .bit_a       (bit_a),
    .bit_sel     (bit_sel),
    .match_bit   (match_bit),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .equal       (equal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popcount_match(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    logic [WIDTH-1:0] m = ~(a ^ b);
    for (int i = 0; i < WIDTH; i++) n += int'(m[i]);
    return n;
  endfunction

  // Model: a comparison accepted at edge s shifts bit (n-s) after edge n for
  // n-s in 0..WIDTH-1, publishes its result at edge s+WIDTH+1, and the block
  // accepts again from edge s+WIDTH+2 on.
  int               cyc     = 0;
  int               s_edge  = -1;
  logic [WIDTH-1:0] cap_a, cap_b;
  int               exp_mc  = 0;
  int               done_cnt = 0;
  int               done_at[$];

  always begin
    int off;
    @(posedge clk);
    cyc++;
    if (rst) begin
      s_edge = -1;
      exp_mc = 0;
    end else begin
      if (s_edge >= 0 && cyc - s_edge == WIDTH + 1)
        exp_mc = popcount_match(cap_a, cap_b);
      if ((s_edge < 0 || cyc - s_edge >= WIDTH + 2) && start) begin
        s_edge = cyc;
        cap_a  = word_a;
        cap_b  = word_b;
      end
    end
    #1;
    off = (s_edge < 0) ? -1 : cyc - s_edge;
    check("busy", 32'(busy), 32'(off >= 0 && off < WIDTH));
    check("done", 32'(done), 32'(off == WIDTH + 1));
    check("bit_a",   32'(bit_a),   (off >= 0 && off < WIDTH) ? 32'(cap_a[off]) : 32'd0);
    check("bit_sel", 32'(bit_sel), (off >= 0 && off < WIDTH) ? 32'(cap_b[off]) : 32'd0);
    check("match_count", 32'(match_count), 32'(exp_mc));
    check("equal", 32'(equal), 32'(exp_mc == WIDTH));
    if (done) begin
      done_cnt++;
      done_at.push_back(cyc);
    end
  end

  // Pulse start with the given words; lat = negedges until done is seen (0 = timeout).
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output logic [WIDTH-1:0] ba, output logic [WIDTH-1:0] bs);
    int nb = 0;
    ba = '0;
    bs = '0;
    lat = 0;
    @(negedge clk);
    start = 1'b1; word_a = a; word_b = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start  = 1'b0;
        word_a = WIDTH'($urandom);
        word_b = WIDTH'($urandom);
      end
      if (busy && nb < WIDTH) begin
        ba[nb] = bit_a;
        bs[nb] = bit_sel;
        nb++;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, d0;
    logic [WIDTH-1:0] ba, bs;
    rst = 1'b1; start = 1'b0; word_a = '0; word_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mc", 32'(match_count), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    run_cmp(8'hA5, 8'hA5, lat, ba, bs);
    check("a5_latency", 32'(lat), 32'd10);
    check("a5_mc", 32'(match_count), 32'd8);
    check("a5_equal", 32'(equal), 32'd1);

    run_cmp(8'hFF, 8'h00, lat, ba, bs);
    check("ff00_mc", 32'(match_count), 32'd0);
    check("ff00_equal", 32'(equal), 32'd0);
    check("ff00_bits_a", 32'(ba), 32'hFF);
    check("ff00_bits_sel", 32'(bs), 32'h00);

    run_cmp(8'hF0, 8'h0F, lat, ba, bs);
    check("f00f_mc", 32'(match_count), 32'd0);
    run_cmp(8'h0F, 8'h0E, lat, ba, bs);
    check("0f0e_mc", 32'(match_count), 32'd7);
    check("0f0e_equal", 32'(equal), 32'd0);

    // Start re-pulsed mid-shift must be ignored.
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; word_a = 8'h3C; word_b = 8'h3C;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; word_a = 8'h00; word_b = 8'hFF;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    check("restart_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("restart_mc", 32'(match_count), 32'd8);

    // Reset during SHIFT aborts without a done pulse.
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; word_a = 8'hF0; word_b = 8'hF0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mc", 32'(match_count), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_cmp(8'h0F, 8'h0E, lat, ba, bs);
    check("after_abort_mc", 32'(match_count), 32'd7);

    // Start held high: back-to-back comparisons with changing words.
    d0 = done_cnt;
    done_at.delete();
    start = 1'b1;
    for (int i = 0; i < 60 && done_cnt - d0 < 3; i++) begin
      @(negedge clk);
      word_a = WIDTH'($urandom);
      word_b = WIDTH'($urandom);
    end
    start = 1'b0;
    check("held_done_count", 32'(done_cnt - d0), 32'd3);
    if (done_at.size() >= 3) begin
      check("held_spacing_1", 32'(done_at[1] - done_at[0]), 32'd10);
      check("held_spacing_2", 32'(done_at[2] - done_at[1]), 32'd10);
    end
    repeat (15) @(negedge clk);

    // Random traffic with occasional resets; the per-cycle model checks it.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 2) == 0);
      word_a = WIDTH'($urandom);
      word_b = ($urandom_range(0, 3) == 0) ? word_a : WIDTH'($urandom);
    end
    rst = 1'b0; start = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_xnor_matcher.md
SERIAL_XNOR_MATCHER -- requirements
Module: serial_xnor_matcher

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the compared word length in bits (legal range 2..32).
REQ-002 The block SHALL have a derived constant CW = clog2(WIDTH+1), the match-count width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 rst, input, 1: synchronous, active-high reset.
REQ-006 start, input, 1: request a comparison; sampled only in IDLE.
REQ-007 word_a, input, WIDTH: first operand; captured on an accepted start.
REQ-008 word_b, input, WIDTH: second operand; captured on an accepted start.
REQ-009 bit_a, output, 1: serial bit of word_a; drives the downstream XNOR-mux data input a.
REQ-010 bit_sel, output, 1: serial bit of word_b; drives the downstream XNOR-mux select sel.
REQ-011 match_bit, input, 1: XNOR-mux result for the current bit (combinational, same cycle).
REQ-012 busy, output, 1: high while bits are being shifted out.
REQ-013 done, output, 1: one-cycle pulse when a result is valid.
REQ-014 match_count, output, CW: number of bit positions where match_bit was 1.
REQ-015 equal, output, 1: high when match_count == WIDTH.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 In IDLE with start=1, the block SHALL capture word_a and word_b into shift registers, clear the internal counters and go to SHIFT on the next edge.
REQ-018 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-019 In SHIFT, bit_a and bit_sel SHALL present the LSB of their shift registers, LSB-first order.
REQ-020 In SHIFT, each edge SHALL add match_bit to an accumulator, shift both registers right by one, and increment a bit index.
REQ-021 The block SHALL stay in SHIFT for exactly WIDTH cycles, then go to DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, match_count and equal SHALL be updated from the accumulator, and the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be WIDTH+2 edges from the accepted start edge to the done-high cycle.
REQ-024 match_count and equal SHALL hold their values until the next DONE or reset.
REQ-025 busy SHALL be 1 only in SHIFT.
REQ-026 start asserted in SHIFT or DONE SHALL be ignored; it is not queued.
REQ-027 start held high continuously SHALL give back-to-back comparisons, with IDLE lasting one cycle between them.
REQ-028 In IDLE and DONE, bit_a and bit_sel SHALL be 0.
REQ-029 The accumulator SHALL be CW bits wide and SHALL never wrap, since its maximum value is WIDTH.
REQ-030 The bit index SHALL count 0..WIDTH-1; the SHIFT-to-DONE transition SHALL occur when index == WIDTH-1.

Reset
REQ-031 On rst=1 at an edge, the FSM SHALL go to IDLE, and busy, done, bit_a, bit_sel, match_count, equal, the accumulator, the index and the shift registers SHALL all be 0.
REQ-032 rst asserted during SHIFT SHALL abort the comparison, with no done pulse and outputs cleared.
REQ-033 rst SHALL take priority over start in the same cycle.

Structure
REQ-034 The state enumeration (IDLE/SHIFT/DONE) and the CW width function SHALL live in a shared package, serial_xnor_pkg.
REQ-035 A single sub-module, piso_shift_reg (parallel-load, right-shift, parameter WIDTH), SHALL be instantiated twice, once for word_a and once for word_b.
REQ-036 The XNOR-mux stage SHALL NOT be inside this block; match_bit SHALL come in from the external stage.

Verification
REQ-037 The testbench SHALL instantiate this block connected to the XNOR-mux stage.
REQ-038 Scenario: WIDTH=8, word_a=8'hA5, word_b=8'hA5, start pulse -> done at edge 10, match_count=8, equal=1.
REQ-039 Scenario: word_a=8'hFF, word_b=8'h00 -> match_count=0, equal=0; bit_a sequence 1,1,...; bit_sel sequence 0,0,...
REQ-040 Scenario: word_a=8'hF0, word_b=8'h0F -> match_count=0; word_a=8'h0F, word_b=8'h0E -> match_count=7, equal=0.
REQ-041 Scenario: start re-pulsed at SHIFT cycle 3 with different words -> ignored; result reflects the first operands; exactly one done pulse.
REQ-042 Scenario: rst at SHIFT cycle 4 -> next cycle busy=0, match_count=0, no done; a fresh start then completes normally.
REQ-043 Scenario: start held high for 3 comparisons -> done pulses spaced WIDTH+2 cycles apart; each match_count is correct.
